// File: rtl/data_ram_arbiter.sv
// Shares the single data_ram port between the openmips data port (M0) and a secondary
// master (M1): round-robin arbitration, bounded M1 burst-lock, and a core stall request.
module data_ram_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1,
  parameter int MAX_LOCK      = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_ce_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  output logic [DATA_W-1:0]   m0_data_o,
  output logic                m0_ack_o,
  output logic                m0_stallreq_o,

  input  logic                m1_ce_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  input  logic                m1_lock_i,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                m1_ack_o,

  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

  state_t            state_q, state_d;
  master_t           grant_q, grant_d;
  master_t           last_grant_q;
  logic              lock_q;      // current/last access was an M1 access with lock requested
  logic [CNT_W-1:0]  cnt_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic              start;
  logic              last_beat;

  assign m0_stallreq_o = m0_ce_i & ~m0_ack_o;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    start     = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_ce_i || m1_ce_i) begin
          start   = 1'b1;
          state_d = ACCESS;
          if (m0_ce_i && m1_ce_i) begin
            if (last_grant_q == M1 && lock_q && lock_cnt_q < LOCK_W'(MAX_LOCK))
              grant_d = M1;
            else
              grant_d = (last_grant_q == M0) ? M1 : M0;
          end else begin
            grant_d = m1_ce_i ? M1 : M0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_W'(ACCESS_CYCLES - 1)) begin
          last_beat = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= M0;
      last_grant_q <= M1;
      lock_q       <= 1'b0;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
      ram_ce_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_sel_o    <= '0;
      ram_data_o   <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      m0_data_o    <= '0;
      m1_data_o    <= '0;
    end else begin
      state_q  <= state_d;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            grant_q  <= grant_d;
            lock_q   <= (grant_d == M1) && m1_lock_i;
            cnt_q    <= '0;
            ram_ce_o <= 1'b1;
            if (grant_d == M1) begin
              ram_we_o   <= m1_we_i;
              ram_addr_o <= m1_addr_i;
              ram_sel_o  <= m1_sel_i;
              ram_data_o <= m1_data_i;
            end else begin
              ram_we_o   <= m0_we_i;
              ram_addr_o <= m0_addr_i;
              ram_sel_o  <= m0_sel_i;
              ram_data_o <= m0_data_i;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_beat) begin
            ram_ce_o <= 1'b0;
            ram_we_o <= 1'b0;
            // Read data is captured on writes too; masters ignore it then.
            if (grant_q == M1) begin
              m1_data_o <= ram_data_i;
              m1_ack_o  <= 1'b1;
            end else begin
              m0_data_o <= ram_data_i;
              m0_ack_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          if (grant_q == M1 && lock_q && m0_ce_i) begin
            if (lock_cnt_q != LOCK_W'(MAX_LOCK))
              lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model (one DUT with 1-cycle, one with 3-cycle access).
module tb_data_ram_arbiter;

  localparam int MAX_LOCK = 4;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } mreq_t;

  typedef struct {
    logic        m0_ce;
    logic        m1_ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        exp_ack0;
    logic        exp_ack1;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
  endfunction

  // ---------------- bus A: ACCESS_CYCLES = 1 ----------------
  logic        a_rst, a_lock, a_init;
  mreq_t       a_m0, a_m1;
  logic [31:0] a_m0_data, a_m1_data, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic        a_m0_ack, a_m1_ack, a_m0_stall, a_ram_ce, a_ram_we;
  logic [3:0]  a_ram_sel;
  logic [31:0] a_mem [256];

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(1), .MAX_LOCK(MAX_LOCK)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .m0_ce_i(a_m0.ce), .m0_we_i(a_m0.we), .m0_addr_i(a_m0.addr), .m0_sel_i(a_m0.sel),
    .m0_data_i(a_m0.data), .m0_data_o(a_m0_data), .m0_ack_o(a_m0_ack), .m0_stallreq_o(a_m0_stall),
    .m1_ce_i(a_m1.ce), .m1_we_i(a_m1.we), .m1_addr_i(a_m1.addr), .m1_sel_i(a_m1.sel),
    .m1_data_i(a_m1.data), .m1_lock_i(a_lock), .m1_data_o(a_m1_data), .m1_ack_o(a_m1_ack),
    .ram_ce_o(a_ram_ce), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr), .ram_sel_o(a_ram_sel),
    .ram_data_o(a_ram_wdata), .ram_data_i(a_ram_rdata)
  );

  assign a_ram_rdata = a_mem[a_ram_addr[9:2]];
  always @(posedge clk) begin
    if (a_init) begin
      for (int i = 0; i < 256; i++) a_mem[i] <= mem_init(i);
    end else if (a_ram_ce && a_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (a_ram_sel[b]) a_mem[a_ram_addr[9:2]][8*b +: 8] <= a_ram_wdata[8*b +: 8];
    end
  end

  // ---------------- bus B: ACCESS_CYCLES = 3 ----------------
  logic        b_rst, b_lock, b_init;
  mreq_t       b_m0, b_m1;
  logic [31:0] b_m0_data, b_m1_data, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_m0_ack, b_m1_ack, b_m0_stall, b_ram_ce, b_ram_we;
  logic [3:0]  b_ram_sel;
  logic [31:0] b_mem [256];

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3), .MAX_LOCK(MAX_LOCK)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .m0_ce_i(b_m0.ce), .m0_we_i(b_m0.we), .m0_addr_i(b_m0.addr), .m0_sel_i(b_m0.sel),
    .m0_data_i(b_m0.data), .m0_data_o(b_m0_data), .m0_ack_o(b_m0_ack), .m0_stallreq_o(b_m0_stall),
    .m1_ce_i(b_m1.ce), .m1_we_i(b_m1.we), .m1_addr_i(b_m1.addr), .m1_sel_i(b_m1.sel),
    .m1_data_i(b_m1.data), .m1_lock_i(b_lock), .m1_data_o(b_m1_data), .m1_ack_o(b_m1_ack),
    .ram_ce_o(b_ram_ce), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr), .ram_sel_o(b_ram_sel),
    .ram_data_o(b_ram_wdata), .ram_data_i(b_ram_rdata)
  );

  assign b_ram_rdata = b_mem[b_ram_addr[9:2]];
  always @(posedge clk) begin
    if (b_init) begin
      for (int i = 0; i < 256; i++) b_mem[i] <= mem_init(i);
    end else if (b_ram_ce && b_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (b_ram_sel[b]) b_mem[b_ram_addr[9:2]][8*b +: 8] <= b_ram_wdata[8*b +: 8];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mreq_t rand_req(input int pct);
    mreq_t r;
    r.ce   = ($urandom_range(0, 99) < 32'(pct));
    r.we   = 1'($urandom_range(0, 1));
    r.addr = 32'($urandom_range(0, 31)) << 2;
    r.sel  = 4'($urandom_range(1, 15));
    r.data = $urandom;
    return r;
  endfunction

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic preload_a();
    a_init = 1'b1;
    @(posedge clk); #1;
    a_init = 1'b0;
  endtask

  task automatic preload_b();
    b_init = 1'b1;
    @(posedge clk); #1;
    b_init = 1'b0;
  endtask

  // Returns in cycle 0: the first cycle the DUT is IDLE out of reset.
  task automatic reset_a();
    a_rst = 1'b1; a_m0 = '0; a_m1 = '0; a_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ram_ce",    a_ram_ce,    0);
    check("rst_ram_we",    a_ram_we,    0);
    check("rst_ram_addr",  a_ram_addr,  0);
    check("rst_ram_sel",   a_ram_sel,   0);
    check("rst_ram_wdata", a_ram_wdata, 0);
    check("rst_m0_ack",    a_m0_ack,    0);
    check("rst_m1_ack",    a_m1_ack,    0);
    check("rst_m0_data",   a_m0_data,   0);
    check("rst_m1_data",   a_m1_data,   0);
    @(posedge clk); #1;
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_m0 = '0; b_m1 = '0; b_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_b_ram_ce", b_ram_ce, 0);
    check("rst_b_m0_ack", b_m0_ack, 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
  endtask

  // Collects up to n acks on bus A and compares master order and timing (3-cycle cadence).
  task automatic collect_acks(input string name, input int n, input int exp_m [16]);
    int got_m [16];
    int got_c [16];
    int cnt = 0;
    for (int c = 0; c < 3 * n + 10 && cnt < n; c++) begin
      @(negedge clk);
      if (a_m0_ack || a_m1_ack) begin
        got_m[cnt] = (a_m0_ack && a_m1_ack) ? 2 : (a_m1_ack ? 1 : 0);
        got_c[cnt] = c;
        cnt++;
      end
    end
    check({name, "_count"}, cnt, n);
    for (int k = 0; k < cnt; k++) begin
      check($sformatf("%s_master%0d", name, k), got_m[k], exp_m[k]);
      check($sformatf("%s_cycle%0d", name, k), got_c[k], 2 + 3 * k);
    end
  endtask

  // Transaction-level reference: each grant occupies the port for exactly 3 cycles
  // (grant cycle, one access cycle, ack cycle); grants follow round-robin with bounded lock.
  task automatic run_random(input int n);
    logic [31:0] mmem [256];
    mreq_t       r;
    bit          busy;
    bit          g_lock, g_we, last_lock;
    int          g_cyc, ack_cyc, gm, last_m, lock_cnt;
    logic [31:0] g_addr, exp_rd;
    logic        e_ce, e_ack0, e_ack1;
    bit          acked [2];
    busy = 0; g_lock = 0; g_we = 0; last_lock = 0;
    g_cyc = 0; ack_cyc = 0; gm = 0; last_m = 1; lock_cnt = 0;
    g_addr = '0; exp_rd = '0;
    acked[0] = 0; acked[1] = 0;
    for (int i = 0; i < 256; i++) mmem[i] = mem_init(i);
    for (int c = 0; c < n; c++) begin
      if (!a_m0.ce || acked[0]) a_m0 = rand_req(70);
      if (!a_m1.ce || acked[1]) begin
        a_m1   = rand_req(80);
        a_lock = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      e_ce   = busy && c > g_cyc && c < ack_cyc;
      e_ack0 = busy && c == ack_cyc && gm == 0;
      e_ack1 = busy && c == ack_cyc && gm == 1;
      check("rnd_ram_ce", a_ram_ce, e_ce);
      check("rnd_ram_we", a_ram_we, e_ce && g_we);
      if (e_ce) check("rnd_ram_addr", a_ram_addr, g_addr);
      check("rnd_m0_ack", a_m0_ack, e_ack0);
      check("rnd_m1_ack", a_m1_ack, e_ack1);
      check("rnd_stall", a_m0_stall, a_m0.ce & ~e_ack0);
      if (e_ack0 && !g_we) check("rnd_m0_data", a_m0_data, exp_rd);
      if (e_ack1 && !g_we) check("rnd_m1_data", a_m1_data, exp_rd);
      acked[0] = 0; acked[1] = 0;
      if (busy && c == ack_cyc) begin
        if (gm == 1 && g_lock && a_m0.ce) lock_cnt = (lock_cnt < MAX_LOCK) ? lock_cnt + 1 : lock_cnt;
        else lock_cnt = 0;
        last_m    = gm;
        last_lock = (gm == 1) && g_lock;
        busy      = 0;
        acked[gm] = 1;
      end else if (!busy && (a_m0.ce || a_m1.ce)) begin
        if (a_m0.ce && a_m1.ce)
          gm = (last_m == 1 && last_lock && lock_cnt < MAX_LOCK) ? 1 : 1 - last_m;
        else
          gm = a_m1.ce ? 1 : 0;
        r       = (gm == 1) ? a_m1 : a_m0;
        g_lock  = (gm == 1) && a_lock;
        g_we    = r.we;
        g_addr  = r.addr;
        g_cyc   = c;
        ack_cyc = c + 2;
        exp_rd  = mmem[r.addr[9:2]];
        if (r.we)
          for (int b = 0; b < 4; b++)
            if (r.sel[b]) mmem[r.addr[9:2]][8*b +: 8] = r.data[8*b +: 8];
        busy = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [10];
  vec_t v;
  int   exp_seq [16];
  int   first_m, first_c;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h20, 4'h2, 32'h0000_AB00, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h20, 4'hF, 32'h0,        1'b1, 1'b0, 32'h1000_AB08};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0,        1'b0, 1'b1, 32'h1000_0005};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h18, 4'hF, 32'h0,        1'b1, 1'b0, 32'h1000_0006};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h18, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h18, 4'hF, 32'h0,        1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h18, 4'hF, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h1C, 4'h8, 32'h7700_0000, 1'b0, 1'b1, 32'h0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h1C, 4'hF, 32'h0,        1'b1, 1'b0, 32'h7700_0007};

    a_init = 1'b0; b_init = 1'b0; a_rst = 1'b1; b_rst = 1'b1;
    a_m0 = '0; a_m1 = '0; b_m0 = '0; b_m1 = '0; a_lock = 1'b0; b_lock = 1'b0;
    @(posedge clk); #1;

    // Vector table: each entry is issued in an IDLE cycle, acked two cycles later.
    preload_a();
    reset_a();
    for (int i = 0; i < 10; i++) begin
      v    = vecs[i];
      a_m0 = '{v.m0_ce, v.we, v.addr, v.sel, v.wdata};
      a_m1 = '{v.m1_ce, v.we, v.addr, v.sel, v.wdata};
      @(negedge clk);
      check($sformatf("vec%0d_stall_c0", i), a_m0_stall, v.m0_ce);
      check($sformatf("vec%0d_ram_ce_c0", i), a_ram_ce, 0);
      @(negedge clk);
      check($sformatf("vec%0d_ram_ce_c1", i), a_ram_ce, v.exp_ack0 | v.exp_ack1);
      check($sformatf("vec%0d_ack_c1", i), {a_m0_ack, a_m1_ack}, 0);
      @(negedge clk);
      check($sformatf("vec%0d_m0_ack", i), a_m0_ack, v.exp_ack0);
      check($sformatf("vec%0d_m1_ack", i), a_m1_ack, v.exp_ack1);
      check($sformatf("vec%0d_stall_c2", i), a_m0_stall, v.m0_ce & ~v.exp_ack0);
      if (v.exp_ack0 && !v.we) check($sformatf("vec%0d_m0_data", i), a_m0_data, v.exp_rdata);
      if (v.exp_ack1 && !v.we) check($sformatf("vec%0d_m1_data", i), a_m1_data, v.exp_rdata);
      @(posedge clk); #1;
    end
    a_m0 = '0; a_m1 = '0;

    // Continuous contention without lock: strict alternation starting with M0.
    reset_a();
    a_m0 = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0};
    a_m1 = '{1'b1, 1'b0, 32'h14, 4'hF, 32'h0};
    exp_seq = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    collect_acks("rr", 4, exp_seq);

    // M1 lock held under contention: MAX_LOCK locked M1 grants, then M0, then the count restarts.
    reset_a();
    a_m0   = '{1'b1, 1'b0, 32'h10, 4'hF, 32'h0};
    a_m1   = '{1'b1, 1'b0, 32'h14, 4'hF, 32'h0};
    a_lock = 1'b1;
    exp_seq = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    collect_acks("lock", 11, exp_seq);

    // Randomized traffic against the reference model.
    preload_a();
    reset_a();
    run_random(3000);

    // Three-cycle access: M0 write holds ce/we for exactly three cycles, ack in cycle 4.
    preload_b();
    reset_b();
    b_m0 = '{1'b1, 1'b1, 32'h30, 4'hF, 32'h1234_5678};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("ac3_ram_ce_c%0d", c), b_ram_ce, (c >= 1 && c <= 3));
      check($sformatf("ac3_ram_we_c%0d", c), b_ram_we, (c >= 1 && c <= 3));
      check($sformatf("ac3_m0_ack_c%0d", c), b_m0_ack, (c == 4));
      if (c == 1) check("ac3_mem_before", b_mem[12], mem_init(12));
      if (c == 4) check("ac3_mem_after", b_mem[12], 32'h1234_5678);
      @(posedge clk); #1;
      if (c == 4) b_m0.ce = 1'b0;
    end

    // Reset during the second access cycle of an M1 read aborts it; the next tie goes to M0.
    b_m1 = '{1'b1, 1'b0, 32'h30, 4'hF, 32'h0};
    @(negedge clk);
    check("rst_mid_ce_c0", b_ram_ce, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_ce_c1", b_ram_ce, 1);
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ce_c2", b_ram_ce, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_ce_after", b_ram_ce, 0);
    check("rst_mid_addr_after", b_ram_addr, 0);
    check("rst_mid_m1_ack_after", b_m1_ack, 0);
    check("rst_mid_m1_data_after", b_m1_data, 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_m0  = '{1'b1, 1'b0, 32'h30, 4'hF, 32'h0};
    first_m = -1;
    first_c = -1;
    for (int c = 0; c < 20 && first_m < 0; c++) begin
      @(negedge clk);
      if (b_m0_ack || b_m1_ack) begin
        first_m = b_m1_ack ? 1 : 0;
        first_c = c;
        if (!b_m1_ack) check("rst_mid_m0_data", b_m0_data, 32'h1234_5678);
      end
    end
    check("rst_mid_first_master", first_m, 0);
    check("rst_mid_first_cycle", first_c, 4);
    b_m0 = '0;
    b_m1 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
